alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits (legal 8..128).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand set present.
REQ-005 SHALL have port in_ready  output  1  block can take an operand set this cycle.
REQ-006 SHALL have port op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 SLTU (unsigned), 111 PASSA.
REQ-007 SHALL have port left  input  WIDTH  operand A.
REQ-008 SHALL have port right  input  WIDTH  operand B.
REQ-009 SHALL have port out_valid  output  1  key and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port key  output  WIDTH  result.
REQ-012 SHALL have port flags  output  4  {zero, neg, carry, ovf} for the result on key.

Function
REQ-013 SHALL be a two-stage pipeline: S1 registers op/left/right, S2 registers key/flags; advance enable adv = ~out_valid | out_ready.
REQ-014 SHALL drive in_ready = adv combinationally; a transfer occurs when in_valid & in_ready at a rising edge.
REQ-015 SHALL present the result of an accepted operand set with out_valid high exactly 2 cycles after acceptance when out_ready stays high (one result per cycle throughput).
REQ-016 SHALL freeze S1 and S2 contents, key and flags while adv is low; no operand set lost or duplicated.
REQ-017 SHALL, when S1 holds no valid data and adv is high, load S2 as empty (out_valid falls after out_ready consumes).
REQ-018 SHALL compute ADD/SUB modulo 2^WIDTH (wrap-around) unless REQ-027 applies.
REQ-019 SHALL set carry = unsigned carry-out for ADD, = borrow (left < right unsigned) for SUB, 0 otherwise.
REQ-020 SHALL set ovf = signed two's-complement overflow for ADD/SUB, 0 otherwise.
REQ-021 SHALL give SLT/SLTU key = 1 (zero-extended) when left < right per signedness, else 0; PASSA key = left.
REQ-022 SHALL set zero = (key == 0) and neg = key[WIDTH-1], evaluated on the final (post-saturation) key.
REQ-023 SHALL accept simultaneous input acceptance and output consumption in one cycle with no bubble.

Reset
REQ-024 SHALL on reset assertion, immediately and regardless of clk, clear S1 valid, S2 valid, key to 0, flags to 0000.
REQ-025 SHALL drop any in-flight operand sets on reset mid-operation; none reappear after release.
REQ-026 SHALL drive in_ready high during and after reset (out_valid low implies adv high).

Configuration
REQ-027 SHALL, with macro ALU_PIPE_SAT_EN defined, saturate signed ADD/SUB overflow to 0111..1 (positive overflow) or 1000..0 (negative overflow), ovf still reported 1; carry unaffected.
REQ-028 SHALL, without ALU_PIPE_SAT_EN, wrap ADD/SUB per REQ-018 and contain no saturation logic.

Verification
REQ-029 SHALL cover: WIDTH=64, ADD left=0xFFFF_FFFF_FFFF_FFFF right=1, out_ready=1 -> 2 cycles later key=0, flags zero=1 carry=1 ovf=0.
REQ-030 SHALL cover: WIDTH=8, ADD 0x7F+0x01 -> key=0x80 flags neg=1 ovf=1 (no macro); key=0x7F neg=0 ovf=1 (ALU_PIPE_SAT_EN).
REQ-031 SHALL cover: WIDTH=64, SUB 3-5 -> key=0xFFFF_FFFF_FFFF_FFFE carry=1 neg=1; SLT 0x80..0 vs 1 -> key=1; SLTU same -> key=0.
REQ-032 SHALL cover: back-to-back stream of 8 ADDs with out_ready held low 3 cycles mid-stream -> in_ready low while stalled, all 8 results delivered in order, none duplicated.
REQ-033 SHALL cover: reset asserted between clk edges with 2 operand sets in flight -> out_valid, key, flags 0 immediately; after release first new input appears 2 cycles after acceptance.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe -- two-stage pipelined ALU with valid/ready handshaking.
//
// Stage S1 captures the opcode and operands; stage S2 captures the result
// (key) and its flags. Both stages advance together whenever the output
// register is empty or being consumed, so a full pipe streams one result
// per cycle and a stalled consumer back-pressures the producer.
//
// Optional feature (compile-time macro ALU_PIPE_SAT_EN):
//   defined   -> signed overflow on ADD/SUB saturates the result to the
//                most positive / most negative value; ovf still reported.
//   undefined -> ADD/SUB wrap modulo 2^WIDTH (default build).
//
// Ports:
//   clk        in   single clock, rising-edge active
//   reset      in   asynchronous, active-high reset
//   in_valid   in   operand set present
//   in_ready   out  block can take an operand set this cycle
//   op[2:0]    in   000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                   101 SLT (signed), 110 SLTU (unsigned), 111 PASSA
//   left       in   operand A, WIDTH bits
//   right      in   operand B, WIDTH bits
//   out_valid  out  key and flags valid
//   out_ready  in   consumer takes the result this cycle
//   key        out  result, WIDTH bits
//   flags[3:0] out  {zero, neg, carry, ovf} for the result on key

module alu_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] key,
  output logic [3:0]       flags
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_SLTU  = 3'b110;

  // Stage S1 state
  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_left_q,  s1_left_d;
  logic [WIDTH-1:0] s1_right_q, s1_right_d;

  // Stage S2 state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] key_q,       key_d;
  logic [3:0]       flags_q,     flags_d;

  // ALU datapath on S1 contents
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sub_res;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_zero;
  logic             alu_neg;

  logic adv;

  // Both stages move together; S2 can only be overwritten once consumed.
  assign adv       = ~out_valid_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign key       = key_q;
  assign flags     = flags_q;

  always_comb begin
    add_full  = {1'b0, s1_left_q} + {1'b0, s1_right_q};
    sub_res   = s1_left_q - s1_right_q;
    // Signed overflow: ADD when operand signs agree but the result sign
    // differs; SUB when operand signs differ and the result sign follows B.
    add_ovf   = (s1_left_q[WIDTH-1] == s1_right_q[WIDTH-1]) &&
                (add_full[WIDTH-1] != s1_left_q[WIDTH-1]);
    sub_ovf   = (s1_left_q[WIDTH-1] != s1_right_q[WIDTH-1]) &&
                (sub_res[WIDTH-1] != s1_left_q[WIDTH-1]);
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        alu_res   = add_full[WIDTH-1:0];
        alu_carry = add_full[WIDTH];
        alu_ovf   = add_ovf;
      end
      OP_SUB: begin
        alu_res   = sub_res;
        alu_carry = (s1_left_q < s1_right_q);
        alu_ovf   = sub_ovf;
      end
      OP_AND:  alu_res = s1_left_q & s1_right_q;
      OP_OR:   alu_res = s1_left_q | s1_right_q;
      OP_XOR:  alu_res = s1_left_q ^ s1_right_q;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          ($signed(s1_left_q) < $signed(s1_right_q))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (s1_left_q < s1_right_q)};
      default: alu_res = s1_left_q;
    endcase
`ifdef ALU_PIPE_SAT_EN
    // Only ADD/SUB can raise ovf. On overflow the true result has the sign
    // of A, so clamp toward that sign.
    if (alu_ovf) begin
      alu_res = s1_left_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    alu_zero = (alu_res == '0);
    alu_neg  = alu_res[WIDTH-1];
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_left_d  = s1_left_q;
    s1_right_d = s1_right_q;
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d    = op;
        s1_left_d  = left;
        s1_right_d = right;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    key_d       = key_q;
    flags_d     = flags_q;
    if (adv) begin
      // An empty S1 moves a bubble into S2; the stale key is left in place.
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        key_d   = alu_res;
        flags_d = {alu_zero, alu_neg, alu_carry, alu_ovf};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_left_q   <= '0;
      s1_right_q  <= '0;
      out_valid_q <= 1'b0;
      key_q       <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_left_q   <= s1_left_d;
      s1_right_q  <= s1_right_d;
      out_valid_q <= out_valid_d;
      key_q       <= key_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, SLT = 3'b101, SLTU = 3'b110, PASSA = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [63:0] left, right, key;
  logic [3:0]  flags;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [2:0]  op8;
  logic [7:0]  left8, right8, key8;
  logic [3:0]  flags8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .left(left), .right(right), .out_valid(out_valid),
    .out_ready(out_ready), .key(key), .flags(flags)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .left(left8), .right(right8), .out_valid(out_valid8),
    .out_ready(out_ready8), .key(key8), .flags(flags8)
  );

  // Present one operand set, then sample one cycle later (must still be
  // empty) and two cycles later (result). Leaves the pipe drained.
  task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        output logic v_early, output logic v, output logic [63:0] k,
                        output logic [3:0] f);
    op = o; left = a; right = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    v_early = out_valid;
    @(posedge clk); #1;
    v = out_valid; k = key; f = flags;
    @(posedge clk); #1;
  endtask

  task automatic run_op8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         output logic v, output logic [7:0] k, output logic [3:0] f);
    op8 = o; left8 = a; right8 = b; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    v = out_valid8; k = key8; f = flags8;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (key !== 64'h0) begin n_fail++; $display("FAIL reset_key got %h exp 0", key); end
    n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", flags); end
    n_checks++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8 got %b exp 0", out_valid8); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_add_wrap();
    logic ve, v; logic [63:0] k; logic [3:0] f;
    run_op(ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, ve, v, k, f);
    n_checks++; if (ve !== 1'b0) begin n_fail++; $display("FAIL add_wrap_early_valid got %b exp 0", ve); end
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL add_wrap_valid got %b exp 1", v); end
    n_checks++; if (k !== 64'h0) begin n_fail++; $display("FAIL add_wrap_key got %h exp 0", k); end
    n_checks++; if (f !== 4'b1010) begin n_fail++; $display("FAIL add_wrap_flags got %b exp 1010", f); end
  endtask

  task automatic test_add8_ovf();
    logic v; logic [7:0] k; logic [3:0] f;
    logic [7:0] ek1, ek2; logic [3:0] ef1, ef2;
`ifdef ALU_PIPE_SAT_EN
    ek1 = 8'h7F; ef1 = 4'b0001;
    ek2 = 8'h80; ef2 = 4'b0111;
`else
    ek1 = 8'h80; ef1 = 4'b0101;
    ek2 = 8'h00; ef2 = 4'b1011;
`endif
    run_op8(ADD, 8'h7F, 8'h01, v, k, f);
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL add8_pos_valid got %b exp 1", v); end
    n_checks++; if (k !== ek1) begin n_fail++; $display("FAIL add8_pos_key got %h exp %h", k, ek1); end
    n_checks++; if (f !== ef1) begin n_fail++; $display("FAIL add8_pos_flags got %b exp %b", f, ef1); end
    run_op8(ADD, 8'h80, 8'h80, v, k, f);
    n_checks++; if (k !== ek2) begin n_fail++; $display("FAIL add8_neg_key got %h exp %h", k, ek2); end
    n_checks++; if (f !== ef2) begin n_fail++; $display("FAIL add8_neg_flags got %b exp %b", f, ef2); end
  endtask

  task automatic test_ops64();
    logic [2:0]  t_op [10];
    logic [63:0] t_a  [10];
    logic [63:0] t_b  [10];
    logic [63:0] t_k  [10];
    logic [3:0]  t_f  [10];
    logic ve, v; logic [63:0] k; logic [3:0] f;
    t_op = '{SUB, SLT, SLTU, SUB, AND_, OR_, XOR_, PASSA, SUB, ADD};
    t_a  = '{64'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd5,
             64'hF0F0, 64'h0F, 64'h8000_0000_0000_0000, 64'h1234,
             64'h8000_0000_0000_0000, 64'h0000_0000_FFFF_FFFF};
    t_b  = '{64'd5, 64'd1, 64'd1, 64'd5, 64'hFF00, 64'hF0, 64'h0,
             64'hDEAD, 64'd1, 64'h1};
    t_k  = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'd0, 64'd0, 64'hF000, 64'hFF,
             64'h8000_0000_0000_0000, 64'h1234,
`ifdef ALU_PIPE_SAT_EN
             64'h8000_0000_0000_0000,
`else
             64'h7FFF_FFFF_FFFF_FFFF,
`endif
             64'h0000_0001_0000_0000};
    t_f  = '{4'b0110, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0000,
`ifdef ALU_PIPE_SAT_EN
             4'b0101,
`else
             4'b0001,
`endif
             4'b0000};
    for (int i = 0; i < 10; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], ve, v, k, f);
      n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL op%0d_valid got %b exp 1", i, v); end
      n_checks++; if (k !== t_k[i]) begin n_fail++; $display("FAIL op%0d_key got %h exp %h", i, k, t_k[i]); end
      n_checks++; if (f !== t_f[i]) begin n_fail++; $display("FAIL op%0d_flags got %b exp %b", i, f, t_f[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_k [8];
    int sent = 0, recv = 0, extra = 0;
    for (int i = 0; i < 8; i++) exp_k[i] = (64'd100 + 64'(i)) + 64'(i * 3);
    op = ADD;
    for (int c = 0; c < 30; c++) begin
      in_valid  = (sent < 8);
      left      = 64'd100 + 64'(sent);
      right     = 64'(sent * 3);
      out_ready = !(c >= 4 && c <= 6);
      #1;
      if (c >= 4 && c <= 6) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready c=%0d got %b exp 0", c, in_ready); end
        n_checks++; if (key !== exp_k[recv]) begin n_fail++; $display("FAIL b2b_stall_key c=%0d got %h exp %h", c, key, exp_k[recv]); end
      end
      if (out_valid && out_ready) begin
        if (recv >= 8) extra++;
        else begin
          n_checks++; if (key !== exp_k[recv]) begin n_fail++; $display("FAIL b2b_key%0d got %h exp %h", recv, key, exp_k[recv]); end
          recv++;
        end
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (recv !== 8) begin n_fail++; $display("FAIL b2b_count got %0d exp 8", recv); end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_duplicates got %0d exp 0", extra); end
    n_checks++; if (sent !== 8) begin n_fail++; $display("FAIL b2b_sent got %0d exp 8", sent); end
  endtask

  task automatic test_reset_midflight();
    logic ve, v; logic [63:0] k; logic [3:0] f;
    out_ready = 1'b1;
    op = SUB; left = 64'd3; right = 64'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    op = ADD; left = 64'hFFFF_FFFF_FFFF_FFFF; right = 64'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b exp 1", out_valid); end
    #3 reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got %b exp 0", out_valid); end
    n_checks++; if (key !== 64'h0) begin n_fail++; $display("FAIL mid_reset_key got %h exp 0", key); end
    n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_flags got %b exp 0000", flags); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_reappear c=%0d got %b exp 0", c, out_valid); end
    end
    run_op(PASSA, 64'h55, 64'h0, ve, v, k, f);
    n_checks++; if (ve !== 1'b0) begin n_fail++; $display("FAIL mid_new_early got %b exp 0", ve); end
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL mid_new_valid got %b exp 1", v); end
    n_checks++; if (k !== 64'h55) begin n_fail++; $display("FAIL mid_new_key got %h exp 55", k); end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; op = ADD; left = '0; right = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; op8 = ADD; left8 = '0; right8 = '0;
    test_reset();
    test_add_wrap();
    test_add8_ovf();
    test_ops64();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
